dcache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache sitting in the memory (M) stage of the pipelined processor. It takes the M-stage access (ALU result as address, store data) and returns the load word to the M/W register. It drives `dhit`, which gates every pipeline register and the PC. On a miss it runs a line writeback and/or refill over a 128-bit handshaked memory port while holding `dhit` low.

---
 rtl/dcache.sv | 142 ++++++++++++++
 tb/tb_dcache.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache for the M stage.
// Misses stall the pipeline through dhit while a victim writeback and/or a
// line refill runs over a 128-bit handshaked memory port.
module dcache #(
  parameter int unsigned LINES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  input  logic         req_we,
  input  logic         req_byte,
  input  logic [31:0]  addr,
  input  logic [31:0]  wdata,
  output logic [31:0]  rdata,
  output logic         dhit,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);
  localparam int unsigned IDXW = $clog2(LINES);
  localparam int unsigned TAGW = 32 - 4 - IDXW;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } state_t;

  state_t state, state_next;

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAGW-1:0]  tag_q  [LINES];
  logic [127:0]     line_q [LINES];

  logic [IDXW-1:0] index;
  logic [TAGW-1:0] tag;
  logic            hit;
  logic [6:0]      word_off;
  logic [6:0]      byte_off;
  logic [127:0]    store_line;
  logic            store_en;
  logic            refill_en;

  assign index = addr[4 +: IDXW];
  assign tag   = addr[31 -: TAGW];
  assign hit   = req_valid & valid_q[index] & (tag_q[index] == tag);
  assign dhit  = ~req_valid | ((state == IDLE) & hit);

  // Word k sits at bits [32k+31:32k]; byte lanes are big-endian, so lane n
  // of a word starts 8*(3-n) bits up, which is ~addr[1:0] scaled by 8.
  assign word_off = {addr[3:2], 5'b0};
  assign byte_off = word_off + {2'b0, ~addr[1:0], 3'b0};

  assign rdata = line_q[index][word_off +: 32];

  assign store_en  = (state == IDLE) & hit & req_we;
  assign refill_en = (state == REFILL) & mem_ready;

  // Merge the store (full word or one byte lane) into the addressed line.
  always_comb begin
    store_line = line_q[index];
    if (req_byte) begin
      store_line[byte_off +: 8] = wdata[7:0];
    end else begin
      store_line[word_off +: 32] = wdata;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and memory-port outputs; memory signals are zero outside a transaction.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        if (req_valid && !hit) begin
          state_next = (valid_q[index] && dirty_q[index]) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[index], index, 4'b0};
        mem_wdata = line_q[index];
        if (mem_ready) begin
          state_next = REFILL;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {tag, index, 4'b0};
        if (mem_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Line valid/dirty flags: cleared by reset, set by refill and store hits.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (refill_en) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (store_en) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Tag and data arrays: refill installs a line, a store hit merges into it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (refill_en) begin
        line_q[index] <= mem_rdata;
        tag_q[index]  <= tag;
      end else if (store_en) begin
        line_q[index] <= store_line;
      end
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed scenarios plus randomized traffic
// checked against a flat-memory reference model and a per-line residency map.
module tb_dcache;
  localparam int unsigned LINES = 4;
  localparam int unsigned IDXW  = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_we;
  logic         req_byte;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         dhit;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int vectors = 0;
  int errors  = 0;

  // Which memory line each cache slot should hold, and whether it was written.
  bit        res_valid [LINES];
  bit        res_dirty [LINES];
  bit [31:0] res_tag   [LINES];
  // gold: architecturally latest value of every word; mem_img: what memory holds.
  bit [31:0] gold    [bit [31:0]];
  bit [31:0] mem_img [bit [31:0]];

  dcache #(.LINES(LINES)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_byte  (req_byte),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .dhit      (dhit),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  function automatic bit [31:0] init_word(bit [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic bit [31:0] mem_word(bit [31:0] a);
    return mem_img.exists(a) ? mem_img[a] : init_word(a);
  endfunction

  function automatic bit [31:0] gold_word(bit [31:0] a);
    return gold.exists(a) ? gold[a] : mem_word(a);
  endfunction

  function automatic bit [127:0] gold_line(bit [31:0] la);
    bit [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = gold_word(la + 32'(4*k));
    return l;
  endfunction

  function automatic bit [127:0] mem_line(bit [31:0] la);
    bit [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = mem_word(la + 32'(4*k));
    return l;
  endfunction

  function automatic void model_store(bit bt, bit [31:0] a, bit [31:0] d);
    bit [31:0] w;
    bit [31:0] m;
    int sh;
    w = gold_word(a & ~32'h3);
    if (bt) begin
      sh = 8 * (3 - int'(a[1:0]));
      m  = 32'hFF << sh;
      w  = (w & ~m) | ((d & 32'hFF) << sh);
    end else begin
      w = d;
    end
    gold[a & ~32'h3] = w;
  endfunction

  // Reset loses every unwritten store: the latest values revert to memory.
  function automatic void model_reset();
    for (int i = 0; i < int'(LINES); i++) begin
      res_valid[i] = 1'b0;
      res_dirty[i] = 1'b0;
    end
    gold.delete();
    foreach (mem_img[k]) gold[k] = mem_img[k];
  endfunction

  // One access from request to completion, acting as the memory side.
  // stall < 0 picks a random 0..3 not-ready cycles per memory phase.
  task automatic do_access(input bit we, input bit bt, input bit [31:0] a,
                           input bit [31:0] d, input int stall,
                           output int cycles, output bit saw_wb,
                           output bit [31:0] wb_addr, output bit [127:0] wb_data,
                           output bit [31:0] got);
    int        idx;
    bit [31:0] tg;
    bit [31:0] la;
    bit [31:0] va;
    bit        exp_hit;
    bit        done;
    bit        complete;
    int        phase;
    int        waited;
    int        need;
    idx     = int'((a >> 4) % LINES);
    tg      = a >> (4 + IDXW);
    la      = a & ~32'hF;
    va      = (res_tag[idx] << (4 + IDXW)) | (32'(idx) << 4);
    exp_hit = res_valid[idx] && (res_tag[idx] == tg);
    need    = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
    waited  = 0;
    phase   = 0;
    done    = 1'b0;
    cycles  = 0;
    saw_wb  = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    got     = '0;
    req_valid = 1'b1;
    req_we    = we;
    req_byte  = bt;
    addr      = a;
    wdata     = d;
    while (!done && cycles < 60) begin
      @(negedge clk);
      cycles++;
      mem_ready = 1'b0;
      complete  = 1'b0;
      case (phase)
        0: begin
          vectors++;
          if (dhit !== exp_hit) begin
            errors++;
            $display("FAIL first_dhit addr=%h got=%b want=%b", a, dhit, exp_hit);
          end
          vectors++;
          if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_mem_req addr=%h got=%b want=0", a, mem_req);
          end
          if (exp_hit) complete = 1'b1;
          else phase = (res_valid[idx] && res_dirty[idx]) ? 1 : 2;
        end
        1: begin
          vectors++;
          if ({dhit, mem_req, mem_we} !== 3'b011) begin
            errors++;
            $display("FAIL wb_ctrl addr=%h got dhit/req/we=%b want=011", a, {dhit, mem_req, mem_we});
          end
          vectors++;
          if (mem_addr !== va) begin
            errors++;
            $display("FAIL wb_addr got=%h want=%h", mem_addr, va);
          end
          vectors++;
          if (mem_wdata !== gold_line(va)) begin
            errors++;
            $display("FAIL wb_data got=%h want=%h", mem_wdata, gold_line(va));
          end
          if (waited >= need) begin
            mem_ready = 1'b1;
            saw_wb    = 1'b1;
            wb_addr   = mem_addr;
            wb_data   = mem_wdata;
            for (int k = 0; k < 4; k++) mem_img[va + 32'(4*k)] = gold_word(va + 32'(4*k));
            phase  = 2;
            waited = 0;
            need   = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
          end else begin
            waited++;
          end
        end
        2: begin
          vectors++;
          if ({dhit, mem_req, mem_we} !== 3'b010) begin
            errors++;
            $display("FAIL rf_ctrl addr=%h got dhit/req/we=%b want=010", a, {dhit, mem_req, mem_we});
          end
          vectors++;
          if (mem_addr !== la) begin
            errors++;
            $display("FAIL rf_addr got=%h want=%h", mem_addr, la);
          end
          if (waited >= need) begin
            mem_ready      = 1'b1;
            mem_rdata      = mem_line(la);
            res_valid[idx] = 1'b1;
            res_dirty[idx] = 1'b0;
            res_tag[idx]   = tg;
            phase          = 3;
          end else begin
            waited++;
          end
        end
        default: begin
          vectors++;
          if (dhit !== 1'b1) begin
            errors++;
            $display("FAIL retry_dhit addr=%h got=%b want=1", a, dhit);
          end
          complete = 1'b1;
        end
      endcase
      if (complete) begin
        if (!we) begin
          got = rdata;
          vectors++;
          if (rdata !== gold_word(a & ~32'h3)) begin
            errors++;
            $display("FAIL load_data addr=%h got=%h want=%h", a, rdata, gold_word(a & ~32'h3));
          end
        end else begin
          model_store(bt, a, d);
          res_dirty[idx] = 1'b1;
        end
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      vectors++;
      errors++;
      $display("FAIL access_timeout addr=%h cycles=%0d limit=60", a, cycles);
    end
    req_valid = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0;
    addr = '0; wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    vectors++;
    if ({mem_req, mem_we} !== 2'b00) begin
      errors++; $display("FAIL reset_req_we got=%b want=00", {mem_req, mem_we});
    end
    vectors++;
    if (mem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr);
    end
    vectors++;
    if (mem_wdata !== 128'h0) begin
      errors++; $display("FAIL reset_mem_wdata got=%h want=0", mem_wdata);
    end
    vectors++;
    if (dhit !== 1'b1) begin
      errors++; $display("FAIL reset_dhit got=%b want=1", dhit);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_cold_load();
    int cyc; bit wb; bit [31:0] wa; bit [127:0] wd; bit [31:0] got;
    mem_img[32'h100] = 32'h11223344;
    do_access(1'b0, 1'b0, 32'h100, 32'h0, 0, cyc, wb, wa, wd, got);
    vectors++;
    if (got !== 32'h11223344) begin
      errors++; $display("FAIL cold_load_data got=%h want=11223344", got);
    end
    vectors++;
    if (cyc !== 3 || wb !== 1'b0) begin
      errors++; $display("FAIL cold_load_cycles got=%0d wb=%b want=3 wb=0", cyc, wb);
    end
  endtask

  task automatic test_store_hit();
    int cyc; bit wb; bit [31:0] wa; bit [127:0] wd; bit [31:0] got;
    do_access(1'b1, 1'b0, 32'h104, 32'hDEADBEEF, 0, cyc, wb, wa, wd, got);
    vectors++;
    if (cyc !== 1) begin
      errors++; $display("FAIL store_hit_cycles got=%0d want=1", cyc);
    end
    do_access(1'b0, 1'b0, 32'h104, 32'h0, 0, cyc, wb, wa, wd, got);
    vectors++;
    if (got !== 32'hDEADBEEF || cyc !== 1) begin
      errors++; $display("FAIL store_reload got=%h/%0d want=deadbeef/1", got, cyc);
    end
  endtask

  task automatic test_byte_store();
    int cyc; bit wb; bit [31:0] wa; bit [127:0] wd; bit [31:0] got;
    do_access(1'b1, 1'b1, 32'h101, 32'h000000AB, 0, cyc, wb, wa, wd, got);
    do_access(1'b0, 1'b0, 32'h100, 32'h0, 0, cyc, wb, wa, wd, got);
    vectors++;
    if (got !== 32'h11AB3344) begin
      errors++; $display("FAIL byte_store got=%h want=11ab3344", got);
    end
  endtask

  task automatic test_dirty_conflict();
    int cyc; bit wb; bit [31:0] wa; bit [127:0] wd; bit [31:0] got;
    do_access(1'b0, 1'b0, 32'h140, 32'h0, 0, cyc, wb, wa, wd, got);
    vectors++;
    if (wb !== 1'b1 || wa !== 32'h100) begin
      errors++; $display("FAIL conflict_wb got wb=%b addr=%h want wb=1 addr=00000100", wb, wa);
    end
    vectors++;
    if (wd[63:0] !== 64'hDEADBEEF_11AB3344) begin
      errors++; $display("FAIL conflict_wb_words got=%h want=deadbeef11ab3344", wd[63:0]);
    end
    vectors++;
    if (cyc !== 4) begin
      errors++; $display("FAIL conflict_cycles got=%0d want=4", cyc);
    end
  endtask

  task automatic test_stall();
    int cyc; bit wb; bit [31:0] wa; bit [127:0] wd; bit [31:0] got;
    req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({dhit, mem_req} !== 2'b10) begin
      errors++; $display("FAIL idle_outputs got dhit/req=%b want=10", {dhit, mem_req});
    end
    @(posedge clk);
    #1;
    do_access(1'b0, 1'b0, 32'h180, 32'h0, 5, cyc, wb, wa, wd, got);
    vectors++;
    if (cyc !== 8) begin
      errors++; $display("FAIL stall_cycles got=%0d want=8", cyc);
    end
  endtask

  task automatic test_reset_refill();
    int cyc; bit wb; bit [31:0] wa; bit [127:0] wd; bit [31:0] got;
    req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; addr = 32'h200; wdata = '0;
    @(negedge clk);
    vectors++;
    if (dhit !== 1'b0) begin
      errors++; $display("FAIL rr_miss got=%b want=0", dhit);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h200) begin
      errors++; $display("FAIL rr_refill got req/we=%b addr=%h want 10 00000200", {mem_req, mem_we}, mem_addr);
    end
    reset = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    vectors++;
    if ({mem_req, dhit} !== 2'b01) begin
      errors++; $display("FAIL rr_abandon got req/dhit=%b want=01", {mem_req, dhit});
    end
    @(posedge clk);
    #1;
    do_access(1'b0, 1'b0, 32'h200, 32'h0, 0, cyc, wb, wa, wd, got);
    vectors++;
    if (cyc !== 3) begin
      errors++; $display("FAIL rr_remiss_cycles got=%0d want=3", cyc);
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit wb; bit [31:0] wa; bit [127:0] wd; bit [31:0] got;
    bit [31:0] a;
    bit we;
    bit bt;
    for (int n = 0; n < 400; n++) begin
      a  = $urandom_range(0, 255);
      we = ($urandom_range(0, 2) == 0);
      bt = we && ($urandom_range(0, 1) == 1);
      do_access(we, bt, a, $urandom, -1, cyc, wb, wa, wd, got);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        vectors++;
        if ({dhit, mem_req} !== 2'b10) begin
          errors++; $display("FAIL gap_idle got dhit/req=%b want=10", {dhit, mem_req});
        end
        @(posedge clk);
        #1;
      end
    end
    // Read back every word touched so dirty data survives evictions.
    for (int w = 0; w < 64; w++) begin
      do_access(1'b0, 1'b0, 32'(4*w), 32'h0, -1, cyc, wb, wa, wd, got);
    end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_store_hit();
    test_byte_store();
    test_dirty_conflict();
    test_stall();
    test_reset_refill();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
